clk_div_ctrl: RTL
=================

// Module: clk_div_ctrl
// PURPOSE
//  Run-time controller for the fabric clock-divider path. Holds the active divide
//  ratio and accepts new ratios over a valid/ready handshake. A new ratio takes
//  effect only on a period boundary, so the output never produces a runt phase.
//  Drives a one-cycle clock-enable strobe and a registered divided square wave
//  (div_clk) for downstream logic running at clk/N.
// PARAMETERS
//  CNT_W        8   width of ratio and period counter; legal N = 2 .. 2**CNT_W-1
//  DEFAULT_DIV  2   ratio loaded at reset; must be a legal N
// PORTS
//  clk        in   1      single system clock; all logic is on its rising edge
//  rst_n      in   1      synchronous, active-low reset
//  en         in   1      1 = run the divider, 0 = stop it and hold outputs low
//  cfg_valid  in   1      a new ratio is offered on cfg_div
//  cfg_div    in   CNT_W  requested divide ratio N
//  cfg_ready  out  1      controller can accept a ratio (decoded from state)
//  cfg_err    out  1      one-cycle pulse: an offered ratio was illegal (0 or 1)
//  busy       out  1      an accepted ratio is waiting for a period boundary
//  clk_en     out  1      one-cycle strobe, once every N cycles
//  div_clk    out  1      registered clk/N wave: high for floor(N/2) cycles per period
// BEHAVIOUR
//  Reset (rst_n=0 at an edge)
//   - state=STOP, cnt=0, cur_div=DEFAULT_DIV, pend_div=DEFAULT_DIV
//   - clk_en=0, div_clk=0, cfg_err=0, busy=0, cfg_ready=1
//   - An active reset overrides every other input, including mid-PEND.
//  States
//   - STOP: cnt held at 0; clk_en=0, div_clk=0.
//   - RUN:  cnt steps 0..cur_div-1, then wraps to 0.
//   - PEND: counts like RUN and holds pend_div.
//  Transitions
//   - STOP->RUN: en=1. cnt=0 in the first RUN cycle.
//   - RUN->STOP: en=0.
//   - RUN->PEND: legal ratio accepted.
//   - PEND->RUN: on the wrap cycle (cnt==cur_div-1), cur_div<=pend_div and cnt<=0.
//   - PEND->STOP: en=0. pend_div is applied immediately.
//  Handshake
//   - Transfer when cfg_valid & cfg_ready.
//   - cfg_ready=1 in STOP and RUN, 0 in PEND. busy = (state==PEND).
//   - In STOP, a legal ratio loads cur_div directly; state stays STOP.
//   - An illegal ratio is still consumed: cfg_err pulses the next cycle, and
//     cur_div, pend_div and state are unchanged.
//  Outputs (flops, aligned to cnt)
//   - In RUN/PEND: clk_en=1 in the cycle where cnt==cur_div-1.
//   - In RUN/PEND: div_clk=1 while cnt < cur_div>>1.
//   - N=2 gives clk_en 0101..., div_clk 1010...
//   - N odd gives a duty of floor(N/2)/N.
//  Simultaneous events
//   - Ratio accept and wrap in the same RUN cycle: the current period ends
//     normally, the state goes to PEND, and the new ratio applies at the next wrap.
//   - en falls while a ratio is offered: the ratio is accepted and loaded, and
//     the state goes to STOP.
//  Width rules
//   - cnt and ratio are unsigned CNT_W.
//   - The cur_div-1 and >>1 results stay in CNT_W; no overflow is possible for legal N.
// STRUCTURE
//  - clk_div_pkg: state_t enum {STOP,RUN,PEND}, MIN_DIV=2, function legal_div(N).
//  - One sub-module, clk_div_counter: cnt register, wrap detect, and the
//    clk_en/div_clk decode flops.
//  - The FSM and handshake stay in clk_div_ctrl.
// TESTING
//  1. Reset then en=1, 20 cycles
//     -> N=2: clk_en high every 2nd cycle starting at cnt=1; div_clk=1,0,1,0...
//  2. In STOP, cfg_div=4 valid for 1 cycle, then en=1
//     -> clk_en period 4; div_clk high 2 / low 2; busy stays 0.
//  3. Running N=4, offer cfg_div=8 at cnt=1
//     -> busy=1 and cfg_ready=0 until the cnt=3 wrap, then periods of 8
//        (div_clk high 4 / low 4).
//  4. Offer cfg_div=1, then cfg_div=0
//     -> cfg_err pulses once per offer; the ratio is unchanged; clk_en period unchanged.
//  5. In PEND (N=8 pending), drop en
//     -> next cycle STOP, outputs 0, busy=0; re-enable -> period 8 from cnt=0.
//  6. Pull rst_n low mid-period while PEND
//     -> next cycle all outputs at reset values, cur_div=DEFAULT_DIV;
//        the bench checks 200 cycles against a reference model.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the run-time clock-divider controller.
// Holds the FSM state encoding and the legal-ratio check.
package clk_div_pkg;

   typedef enum logic [1:0] {
      STOP = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   localparam int unsigned MIN_DIV = 2;

   function automatic logic legal_div(input int unsigned n);
      return (n >= MIN_DIV);
   endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Period counter for the clock divider: steps cnt, flags the wrap cycle and
// registers the clk_en strobe and div_clk wave from the next-cycle count.
module clk_div_counter
   import clk_div_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             active_i,
   input  logic             active_next_i,
   input  logic [CNT_W-1:0] div_i,
   input  logic [CNT_W-1:0] div_next_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             wrap_o,
   output logic             clk_en_o,
   output logic             div_clk_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clk_en_q, div_clk_q;
   logic [CNT_W-1:0] last_next;
   logic [CNT_W-1:0] half_next;

   assign wrap_o    = (cnt_q == (div_i - 1'b1));
   assign last_next = div_next_i - 1'b1;
   assign half_next = div_next_i >> 1;

   // A period restarts at 0 on wrap, on leaving STOP, and whenever we stop.
   always_comb begin
      cnt_d = '0;
      if (active_i && active_next_i && !wrap_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Outputs are decoded from the values the registers take this edge,
   // so they line up with cnt in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         clk_en_q  <= 1'b0;
         div_clk_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         clk_en_q  <= active_next_i && (cnt_d == last_next);
         div_clk_q <= active_next_i && (cnt_d < half_next);
      end
   end

   assign cnt_o     = cnt_q;
   assign clk_en_o  = clk_en_q;
   assign div_clk_o = div_clk_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time controller for the fabric clock divider: ratio handshake, FSM
// that defers new ratios to a period boundary, and the counter instance.
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int CNT_W       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             busy,
   output logic             clk_en,
   output logic             div_clk
);

   localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cur_div_q, cur_div_d;
   logic [CNT_W-1:0] pend_div_q, pend_div_d;
   logic             cfg_err_q, cfg_err_d;
   logic             accept, legal, load, wrap;
   logic [CNT_W-1:0] cnt;

   assign cfg_ready = (state_q != PEND);
   assign busy      = (state_q == PEND);
   assign cfg_err   = cfg_err_q;
   assign accept    = cfg_valid && cfg_ready;
   assign legal     = legal_div(32'(cfg_div));
   assign load      = accept && legal;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= STOP;
         cur_div_q  <= DEF_DIV;
         pend_div_q <= DEF_DIV;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_div_q  <= cur_div_d;
         pend_div_q <= pend_div_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cur_div_d  = cur_div_q;
      pend_div_d = pend_div_q;
      cfg_err_d  = accept && !legal;
      unique case (state_q)
         STOP: begin
            if (load) cur_div_d = cfg_div;
            if (en) state_d = RUN;
         end
         RUN: begin
            // Stopping lets a new ratio bypass the boundary wait entirely.
            if (!en) begin
               state_d = STOP;
               if (load) cur_div_d = cfg_div;
            end else if (load) begin
               pend_div_d = cfg_div;
               state_d    = PEND;
            end
         end
         PEND: begin
            if (!en) begin
               state_d   = STOP;
               cur_div_d = pend_div_q;
            end else if (wrap) begin
               state_d   = RUN;
               cur_div_d = pend_div_q;
            end
         end
         default: state_d = STOP;
      endcase
   end

   clk_div_counter #(
      .CNT_W(CNT_W)
   ) u_counter (
      .clk          (clk),
      .rst_n        (rst_n),
      .active_i     (state_q != STOP),
      .active_next_i(state_d != STOP),
      .div_i        (cur_div_q),
      .div_next_i   (cur_div_d),
      .cnt_o        (cnt),
      .wrap_o       (wrap),
      .clk_en_o     (clk_en),
      .div_clk_o    (div_clk)
   );

endmodule
